// File: rtl/key_scan_filter_pkg.sv
// Shared types and helpers for the key scan / debounce filter.
// Holds the per-key FSM encoding and the priority-encoder helper.
package key_scan_filter_pkg;

    localparam int KEY_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILT_DN = 2'd1,
        ST_HELD    = 2'd2,
        ST_FILT_UP = 2'd3
    } key_fsm_e;

    // Lowest set bit wins; an all-zero vector returns 0.
    function automatic logic [2:0] lowest_index(input logic [KEY_MAX-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = KEY_MAX - 1; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce counter, press FSM,
// long-press counter and the registered event pulses.
module key_filter_ch
    import key_scan_filter_pkg::*;
#(
    parameter logic [24:0] CNT_MAX  = 25'd999_999,
    parameter logic [31:0] LONG_MAX = 32'd49_999_999
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_key_state,
    output logic o_key_press,
    output logic o_key_release,
    output logic o_key_long,
    output logic o_press_next
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_stable;
    logic [24:0] r_cnt;
    logic        r_state;
    logic        r_press;
    logic        r_release;
    logic        r_long;
    logic [31:0] r_long_cnt;
    logic        r_long_seen;
    key_fsm_e    r_fsm;
    key_fsm_e    w_fsm_next;
    logic        w_done;
    logic        w_hold;
    logic        w_press_next;
    logic        w_release_next;
    logic        w_long_hit;
    logic        w_press_entry;

    assign w_done         = (r_sync2 != r_stable) && (r_cnt == CNT_MAX);
    assign w_hold         = (r_fsm == ST_HELD) || (r_fsm == ST_FILT_UP);
    assign w_press_next   = ~r_stable & ~r_state;
    assign w_release_next = r_stable & r_state;
    assign w_press_entry  = (r_fsm == ST_FILT_DN) && (w_fsm_next == ST_HELD);
    assign w_long_hit     = w_hold && r_state && (r_long_cnt == LONG_MAX) && !r_long_seen;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b1;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 25'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_fsm <= ST_IDLE;
        else          r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE:    if (!r_sync2) w_fsm_next = ST_FILT_DN;
            ST_FILT_DN: begin
                if (r_sync2)     w_fsm_next = ST_IDLE;
                else if (w_done) w_fsm_next = ST_HELD;
            end
            ST_HELD:    if (r_sync2) w_fsm_next = ST_FILT_UP;
            ST_FILT_UP: begin
                if (!r_sync2)    w_fsm_next = ST_HELD;
                else if (w_done) w_fsm_next = ST_IDLE;
            end
            default:    w_fsm_next = ST_IDLE;
        endcase
    end

    // Only a fresh press re-arms the long counter; a release bounce that
    // falls back into HELD keeps the count so key_long cannot repeat.
    // Counting is qualified by key_state so the hold is timed from key_press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_long_cnt  <= '0;
            r_long_seen <= 1'b0;
        end else if (w_press_entry) begin
            r_long_cnt  <= '0;
            r_long_seen <= 1'b0;
        end else begin
            if (w_hold && r_state && (r_long_cnt != LONG_MAX))
                r_long_cnt <= r_long_cnt + 32'd1;
            if (w_long_hit)
                r_long_seen <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= ~r_stable;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_long    <= w_long_hit;
        end
    end

    assign o_key_state   = r_state;
    assign o_key_press   = r_press;
    assign o_key_release = r_release;
    assign o_key_long    = r_long;
    assign o_press_next  = w_press_next;

endmodule

// File: rtl/key_scan_filter.sv
// Key scan front end: one debounce channel per key plus a registered
// priority encoder that reports the lowest pressed key index.
module key_scan_filter
    import key_scan_filter_pkg::*;
#(
    parameter int          KEY_W    = 4,
    parameter logic [24:0] CNT_MAX  = 25'd999_999,
    parameter logic [31:0] LONG_MAX = 32'd49_999_999
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_long,
    output logic [2:0]       key_code,
    output logic             key_valid
);

    logic [KEY_W-1:0]   w_press_next;
    logic [KEY_MAX-1:0] w_press_pad;
    logic [2:0]         r_code;
    logic               r_valid;

    generate
        for (genvar g = 0; g < KEY_W; g++) begin : g_ch
            key_filter_ch #(
                .CNT_MAX  (CNT_MAX),
                .LONG_MAX (LONG_MAX)
            ) u_ch (
                .i_clk         (sys_clk),
                .i_rst_n       (sys_rst_n),
                .i_key_n       (key_in[g]),
                .o_key_state   (key_state[g]),
                .o_key_press   (key_press[g]),
                .o_key_release (key_release[g]),
                .o_key_long    (key_long[g]),
                .o_press_next  (w_press_next[g])
            );
        end
    endgenerate

    always_comb begin
        w_press_pad = '0;
        w_press_pad[KEY_W-1:0] = w_press_next;
    end

    // Registered from the channels' next-cycle press so code/valid line up with key_press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_code  <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= |w_press_next;
            if (|w_press_next) r_code <= lowest_index(w_press_pad);
        end
    end

    assign key_code  = r_code;
    assign key_valid = r_valid;

endmodule

// File: tb/tb_key_scan_filter.sv
// Directed bench for key_scan_filter: stimulus pushes expected events into a
// queue, a negedge monitor pops and compares whenever the DUT reports one.
module tb_key_scan_filter;

    localparam int LAT  = 28;
    localparam int LHLD = 100;

    logic       clk;
    logic       rstN;
    logic [3:0] keyIn;
    logic [3:0] keyState;
    logic [3:0] keyPress;
    logic [3:0] keyRelease;
    logic [3:0] keyLong;
    logic [2:0] keyCode;
    logic       keyValid;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] state;
        logic [2:0] code;
    } ev_t;

    ev_t expQ[$];
    ev_t monEv;
    int  cyc    = 0;
    int  nCheck = 0;
    int  nPass  = 0;
    int  edgeCyc;

    key_scan_filter #(
        .KEY_W    (4),
        .CNT_MAX  (25'd24),
        .LONG_MAX (32'd99)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rstN),
        .key_in      (keyIn),
        .key_state   (keyState),
        .key_press   (keyPress),
        .key_release (keyRelease),
        .key_long    (keyLong),
        .key_code    (keyCode),
        .key_valid   (keyValid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] keys, output int ec);
        keyIn = keys;
        ec    = cyc;
    endtask

    task automatic pushEv(input int c, input logic [3:0] p, input logic [3:0] r,
                          input logic [3:0] l, input logic [3:0] s, input logic [2:0] cd);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.state = s; e.code = cd;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCheck++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if ((keyPress | keyRelease | keyLong) != 4'd0 || keyValid !== 1'b0) begin
            nCheck++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_event: cyc=%0d press=%b rel=%b long=%b valid=%b, expected no event",
                         cyc, keyPress, keyRelease, keyLong, keyValid);
            end else begin
                monEv = expQ.pop_front();
                if (cyc == monEv.cyc && keyPress === monEv.press && keyRelease === monEv.rel &&
                    keyLong === monEv.lng && keyState === monEv.state &&
                    keyValid === (monEv.press != 4'd0) && keyCode === monEv.code) begin
                    nPass++;
                end else begin
                    $display("[TB] FAIL event: got cyc=%0d press=%b rel=%b long=%b state=%b valid=%b code=%0d, expected cyc=%0d press=%b rel=%b long=%b state=%b valid=%b code=%0d",
                             cyc, keyPress, keyRelease, keyLong, keyState, keyValid, keyCode,
                             monEv.cyc, monEv.press, monEv.rel, monEv.lng, monEv.state,
                             (monEv.press != 4'd0), monEv.code);
                end
            end
        end
    end

    initial begin
        rstN  = 1'b0;
        keyIn = 4'hF;
        stepCycles(3);
        @(negedge clk);
        checkOutput("reset_state",   32'(keyState),   32'h0);
        checkOutput("reset_press",   32'(keyPress),   32'h0);
        checkOutput("reset_release", 32'(keyRelease), 32'h0);
        checkOutput("reset_long",    32'(keyLong),    32'h0);
        checkOutput("reset_valid",   32'(keyValid),   32'h0);
        checkOutput("reset_code",    32'(keyCode),    32'h0);
        stepCycles(1);
        rstN = 1'b1;
        stepCycles(5);

        $display("[TB] clean press and long hold on key 0");
        applyStimulus(4'b1110, edgeCyc);
        pushEv(edgeCyc + LAT,        4'b0001, 4'b0000, 4'b0000, 4'b0001, 3'd0);
        pushEv(edgeCyc + LAT + LHLD, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 3'd0);
        stepCycles(200);
        applyStimulus(4'b1111, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 3'd0);
        stepCycles(60);

        $display("[TB] bouncing key 1");
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b1101 : 4'b1111, edgeCyc);
            stepCycles(10);
        end
        applyStimulus(4'b1101, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 3'd1);
        stepCycles(60);
        applyStimulus(4'b1111, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 3'd1);
        stepCycles(60);

        $display("[TB] glitch of 24 cycles rejected, 25 cycles accepted on key 2");
        applyStimulus(4'b1011, edgeCyc);
        stepCycles(24);
        applyStimulus(4'b1111, edgeCyc);
        stepCycles(40);
        checkOutput("glitch_state", 32'(keyState), 32'h0);
        applyStimulus(4'b1011, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 3'd2);
        stepCycles(25);
        applyStimulus(4'b1111, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 3'd2);
        stepCycles(40);

        $display("[TB] long hold on key 3");
        applyStimulus(4'b0111, edgeCyc);
        pushEv(edgeCyc + LAT,        4'b1000, 4'b0000, 4'b0000, 4'b1000, 3'd3);
        pushEv(edgeCyc + LAT + LHLD, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 3'd3);
        stepCycles(300);
        applyStimulus(4'b1111, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 3'd3);
        stepCycles(40);

        $display("[TB] simultaneous presses and crossed press/release");
        applyStimulus(4'b0011, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b1100, 4'b0000, 4'b0000, 4'b1100, 3'd2);
        stepCycles(40);
        applyStimulus(4'b1001, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b0010, 4'b1000, 4'b0000, 4'b0110, 3'd1);
        stepCycles(40);
        applyStimulus(4'b1111, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 3'd1);
        stepCycles(40);

        $display("[TB] reset while key 3 held and key 0 filtering");
        applyStimulus(4'b0111, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 3'd3);
        stepCycles(40);
        applyStimulus(4'b0110, edgeCyc);
        stepCycles(12);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midreset_state", 32'(keyState), 32'h0);
        checkOutput("midreset_code",  32'(keyCode),  32'h0);
        checkOutput("midreset_valid", 32'(keyValid), 32'h0);
        stepCycles(5);
        rstN = 1'b1;
        pushEv(cyc + LAT, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 3'd0);
        stepCycles(40);
        applyStimulus(4'b1111, edgeCyc);
        pushEv(edgeCyc + LAT, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 3'd0);
        stepCycles(40);

        checkOutput("pending_events", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", nPass, nCheck);
        $finish;
    end

endmodule
